// File: rtl/axi_counter_bank.sv
// Bank of independent up/down counters with multi-unit steps, wrap or saturate
// behaviour, registered zero/max/threshold flags and a sticky wrap/clamp event.

module axi_counter_bank_ch #(
   parameter int                 C_WIDTH      = 8,
   parameter int                 C_STEP_WIDTH = 4,
   parameter bit                 C_SATURATE   = 1'b0,
   parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clken,
   input  logic                    load,
   input  logic [C_WIDTH-1:0]      load_value,
   input  logic                    incr,
   input  logic [C_STEP_WIDTH-1:0] incr_step,
   input  logic                    decr,
   input  logic [C_STEP_WIDTH-1:0] decr_step,
   input  logic [C_WIDTH-1:0]      threshold,
   input  logic                    clear_event,
   output logic [C_WIDTH-1:0]      count,
   output logic                    is_zero,
   output logic                    is_max,
   output logic                    at_threshold,
   output logic                    event_flag
);
   localparam int SW = C_WIDTH + 2;

   logic [SW-1:0]      inc_ext, dec_ext, sum;
   logic               ovf, unf;
   logic [C_WIDTH-1:0] step_cnt, nxt_cnt;

   // Two guard bits: bit C_WIDTH flags overflow, the sign bit flags underflow.
   assign inc_ext = incr ? SW'(incr_step) : '0;
   assign dec_ext = decr ? SW'(decr_step) : '0;
   assign sum     = {2'b00, count} + inc_ext - dec_ext;
   assign unf     = sum[SW-1];
   assign ovf     = ~sum[SW-1] & sum[C_WIDTH];

   always_comb begin
      step_cnt = sum[C_WIDTH-1:0];
      if (C_SATURATE) begin
         if (ovf)      step_cnt = '1;
         else if (unf) step_cnt = '0;
      end
   end

   assign nxt_cnt = load ? load_value : step_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= C_INIT;
         is_zero      <= (C_INIT == '0);
         is_max       <= (C_INIT == '1);
         at_threshold <= 1'b0;
         event_flag   <= 1'b0;
      end else if (clken) begin
         count        <= nxt_cnt;
         is_zero      <= (nxt_cnt == '0);
         is_max       <= (nxt_cnt == '1);
         at_threshold <= (nxt_cnt >= threshold);
         // A wrap/clamp in the same cycle beats a clear request.
         if (load)             event_flag <= 1'b0;
         else if (ovf || unf)  event_flag <= 1'b1;
         else if (clear_event) event_flag <= 1'b0;
      end
   end
endmodule

module axi_counter_bank #(
   parameter int                 C_NUM_CH     = 4,
   parameter int                 C_WIDTH      = 8,
   parameter int                 C_STEP_WIDTH = 4,
   parameter bit                 C_SATURATE   = 1'b0,
   parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clken,
   input  logic [C_NUM_CH-1:0]              load,
   input  logic [C_NUM_CH*C_WIDTH-1:0]      load_value,
   input  logic [C_NUM_CH-1:0]              incr,
   input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] incr_step,
   input  logic [C_NUM_CH-1:0]              decr,
   input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] decr_step,
   input  logic [C_NUM_CH*C_WIDTH-1:0]      threshold,
   input  logic [C_NUM_CH-1:0]              clear_event,
   output logic [C_NUM_CH*C_WIDTH-1:0]      count,
   output logic [C_NUM_CH-1:0]              is_zero,
   output logic [C_NUM_CH-1:0]              is_max,
   output logic [C_NUM_CH-1:0]              at_threshold,
   output logic [C_NUM_CH-1:0]              event_flag
);
   for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
      axi_counter_bank_ch #(
         .C_WIDTH     (C_WIDTH),
         .C_STEP_WIDTH(C_STEP_WIDTH),
         .C_SATURATE  (C_SATURATE),
         .C_INIT      (C_INIT)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .clken       (clken),
         .load        (load[i]),
         .load_value  (load_value[i*C_WIDTH +: C_WIDTH]),
         .incr        (incr[i]),
         .incr_step   (incr_step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
         .decr        (decr[i]),
         .decr_step   (decr_step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
         .threshold   (threshold[i*C_WIDTH +: C_WIDTH]),
         .clear_event (clear_event[i]),
         .count       (count[i*C_WIDTH +: C_WIDTH]),
         .is_zero     (is_zero[i]),
         .is_max      (is_max[i]),
         .at_threshold(at_threshold[i]),
         .event_flag  (event_flag[i])
      );
   end
endmodule
